// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared types and constants for the MAC array sequencer.
//   state_t      - sequencer FSM state encoding
//   INST_*       - array instruction encodings driven on inst_w
//   MODE_*       - array dataflow modes
//   cnt_width()  - phase counter width for a given configuration
package mac_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_GAP   = 3'd2,
        S_EXEC  = 3'd3,
        S_DRAIN = 3'd4,
        S_FLUSH = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [1:0] INST_NOP  = 2'b00;
    localparam logic [1:0] INST_LOAD = 2'b01;
    localparam logic [1:0] INST_EXEC = 2'b10;

    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

    // Wide enough for the longest phase: either the largest execute length
    // or the WS drain (row+col-1). The counter only ever holds length-1.
    function automatic int cnt_width(input int len_bw, input int row, input int col);
        int len_max;
        int m;
        len_max = (1 << len_bw) - 1;
        m       = (len_max > row + col) ? len_max : row + col;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/mac_array_seq_phase_cnt.sv
// seq_phase_cnt: loadable down-counter shared by every timed phase.
//   clk, reset - clock and synchronous active-low reset
//   load       - start a new phase of load_val cycles (load_val >= 1)
//   load_val   - phase length in cycles
//   tc         - high in the last cycle of the current phase
//   idx        - cycles elapsed in the phase (0 in the first cycle)
module seq_phase_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc,
    output logic [W-1:0] idx
);

    logic [W-1:0] remaining;

    // remaining counts down to zero and then parks there, so tc stays high
    // in phases that are not timed (GAP, DONE, IDLE) without harm.
    always_ff @(posedge clk) begin
        if (!reset) begin
            remaining <= '0;
            idx       <= '0;
        end else if (load) begin
            remaining <= load_val - W'(1);
            idx       <= '0;
        end else if (remaining != '0) begin
            remaining <= remaining - W'(1);
            idx       <= idx + W'(1);
        end
    end

    assign tc = (remaining == '0);

endmodule

// File: rtl/mac_array_seq.sv
// mac_array_seq: steps one MAC-array tile through kernel load, execute and
// drain (WS) or flush (OS), driving array controls and SRAM read strobes.
//   clk, reset        - clock, synchronous active-low reset
//   start             - command strobe
//   cfg_mode, cfg_len - dataflow mode (0=WS, 1=OS) and execute length
//   busy, done        - busy outside IDLE; done pulses for one cycle at the end
//   mode, inst_w      - array mode and instruction (bit0 load, bit1 execute)
//   w_rd_en, w_addr   - weight SRAM read strobe/address (LOAD)
//   x_rd_en, x_addr   - activation SRAM read strobe/address (EXEC)
//   drain_en          - output capture window (DRAIN / FLUSH)
//   dbg_state         - current FSM state
//
// Handshake: start is a plain strobe, not valid/ready. It is taken only when
// the FSM is in IDLE at a clk edge (cfg_* sampled on that same edge); any
// start seen while busy, DONE included, is dropped. busy low means the next
// start will be taken.
module mac_array_seq
    import mac_seq_pkg::*;
#(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int len_bw  = 8,
    parameter int addr_bw = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               cfg_mode,
    input  logic [len_bw-1:0]  cfg_len,
    output logic               busy,
    output logic               done,
    output logic               mode,
    output logic [1:0]         inst_w,
    output logic               w_rd_en,
    output logic [addr_bw-1:0] w_addr,
    output logic               x_rd_en,
    output logic [addr_bw-1:0] x_addr,
    output logic               drain_en,
    output state_t             dbg_state
);

    localparam int CNT_W = cnt_width(len_bw, row, col);

    state_t              state_q, state_nxt;
    logic                mode_q;
    logic [len_bw-1:0]   len_q;
    logic                cnt_load;
    logic [CNT_W-1:0]    cnt_val;
    logic                cnt_tc;
    logic [CNT_W-1:0]    cnt_idx;
    logic [addr_bw-1:0]  idx_addr;
    logic [addr_bw-1:0]  w_hold, x_hold;
    logic                accept;

    assign accept   = (state_q == S_IDLE) && start;
    assign idx_addr = addr_bw'(cnt_idx);

    seq_phase_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tc       (cnt_tc),
        .idx      (cnt_idx)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            mode_q  <= MODE_WS;
            len_q   <= '0;
            w_hold  <= '0;
            x_hold  <= '0;
        end else begin
            state_q <= state_nxt;
            if (accept) begin
                mode_q <= cfg_mode;
                len_q  <= cfg_len;
                w_hold <= '0;
                x_hold <= '0;
            end else begin
                // Track the live index so the address holds its last value
                // once the phase is over.
                if (state_q == S_LOAD) w_hold <= idx_addr;
                if (state_q == S_EXEC) x_hold <= idx_addr;
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_load  = 1'b0;
        cnt_val   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                    cnt_load  = 1'b1;
                    cnt_val   = CNT_W'(col);
                end
            end
            S_LOAD: begin
                if (cnt_tc) state_nxt = S_GAP;
            end
            S_GAP, S_EXEC: begin
                if (state_q == S_GAP && len_q != '0) begin
                    state_nxt = S_EXEC;
                    cnt_load  = 1'b1;
                    cnt_val   = CNT_W'(len_q);
                end else if (state_q == S_GAP || cnt_tc) begin
                    // Zero-length execute falls straight through from GAP.
                    cnt_load = 1'b1;
                    if (mode_q == MODE_OS) begin
                        state_nxt = S_FLUSH;
                        cnt_val   = CNT_W'(row);
                    end else begin
                        state_nxt = S_DRAIN;
                        cnt_val   = CNT_W'(row + col - 1);
                    end
                end
            end
            S_DRAIN, S_FLUSH: begin
                if (cnt_tc) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore decode: everything below depends only on registered state.
    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = 1'b0;
        mode     = MODE_WS;
        inst_w   = INST_NOP;
        w_rd_en  = 1'b0;
        x_rd_en  = 1'b0;
        drain_en = 1'b0;
        w_addr   = w_hold;
        x_addr   = x_hold;
        unique case (state_q)
            S_LOAD: begin
                inst_w  = INST_LOAD;
                w_rd_en = 1'b1;
                mode    = mode_q;
                w_addr  = idx_addr;
            end
            S_GAP: begin
                mode = mode_q;
            end
            S_EXEC: begin
                inst_w  = INST_EXEC;
                x_rd_en = 1'b1;
                mode    = mode_q;
                x_addr  = idx_addr;
            end
            S_DRAIN: begin
                drain_en = 1'b1;
            end
            S_FLUSH: begin
                // Execute with mode forced to WS and no activation reads
                // pushes zeros in and shifts accumulated sums out.
                inst_w   = INST_EXEC;
                drain_en = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_mac_array_seq.sv
module tb_mac_array_seq;
    import mac_seq_pkg::*;

    localparam int ROW = 8;
    localparam int COL = 8;
    localparam int AW  = 11;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          mode;
        logic [1:0]    inst_w;
        logic          w_rd_en;
        logic [AW-1:0] w_addr;
        logic          x_rd_en;
        logic [AW-1:0] x_addr;
        logic          drain_en;
    } obs_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          cfg_mode;
    logic [7:0]    cfg_len;
    logic          busy, done, mode, w_rd_en, x_rd_en, drain_en;
    logic [1:0]    inst_w;
    logic [AW-1:0] w_addr, x_addr;
    state_t        dbg_state;

    obs_t tr[$];
    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    mac_array_seq #(.row(ROW), .col(COL), .len_bw(8), .addr_bw(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cfg_mode  (cfg_mode),
        .cfg_len   (cfg_len),
        .busy      (busy),
        .done      (done),
        .mode      (mode),
        .inst_w    (inst_w),
        .w_rd_en   (w_rd_en),
        .w_addr    (w_addr),
        .x_rd_en   (x_rd_en),
        .x_addr    (x_addr),
        .drain_en  (drain_en),
        .dbg_state (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    function automatic obs_t sample_outputs();
        obs_t s;
        s.busy     = busy;
        s.done     = done;
        s.mode     = mode;
        s.inst_w   = inst_w;
        s.w_rd_en  = w_rd_en;
        s.w_addr   = w_addr;
        s.x_rd_en  = x_rd_en;
        s.x_addr   = x_addr;
        s.drain_en = drain_en;
        return s;
    endfunction

    function automatic obs_t mk(input logic b, input logic d, input logic m, input logic [1:0] iw,
                                input logic we, input int wa, input logic xe, input int xa,
                                input logic de);
        obs_t s;
        s = {b, d, m, iw, we, AW'(wa), xe, AW'(xa), de};
        return s;
    endfunction

    // Expected per-cycle trace from the first LOAD cycle through the IDLE
    // cycle that follows DONE.
    task automatic build_exp(input logic m, input int len);
        int xa;
        exp_q.delete();
        for (int i = 0; i < COL; i++) exp_q.push_back(mk(1, 0, m, 2'b01, 1, i, 0, 0, 0));
        exp_q.push_back(mk(1, 0, m, 2'b00, 0, COL - 1, 0, 0, 0));
        for (int i = 0; i < len; i++) exp_q.push_back(mk(1, 0, m, 2'b10, 0, COL - 1, 1, i, 0));
        xa = (len > 0) ? len - 1 : 0;
        if (m == 1'b0) begin
            for (int i = 0; i < ROW + COL - 1; i++) exp_q.push_back(mk(1, 0, 0, 2'b00, 0, COL - 1, 0, xa, 1));
        end else begin
            for (int i = 0; i < ROW; i++) exp_q.push_back(mk(1, 0, 0, 2'b10, 0, COL - 1, 0, xa, 1));
        end
        exp_q.push_back(mk(1, 1, 0, 2'b00, 0, COL - 1, 0, xa, 0));
        exp_q.push_back(mk(0, 0, 0, 2'b00, 0, COL - 1, 0, xa, 0));
    endtask

    // driver: issue one command and record outputs until one cycle past done
    task automatic run_cmd(input logic m, input logic [7:0] len, input bit scramble);
        int n;
        logic seen;
        start    = 1'b1;
        cfg_mode = m;
        cfg_len  = len;
        @(posedge clk); #1;
        start = 1'b0;
        tr.delete();
        tr.push_back(sample_outputs());
        seen = done;
        n = 1;
        while (!seen && n < 200) begin
            if (scramble) begin
                cfg_mode = 1'($urandom_range(0, 1));
                cfg_len  = 8'($urandom_range(0, 255));
            end
            @(posedge clk); #1;
            tr.push_back(sample_outputs());
            seen = done;
            n++;
        end
        if (seen) begin
            @(posedge clk); #1;
            tr.push_back(sample_outputs());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; cfg_mode = 1'b0; cfg_len = '0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (sample_outputs() !== obs_t'(0)) begin
            n_err++;
            $display("FAIL reset_outputs: got %h, expected 0", sample_outputs());
        end
        n_cmp++;
        if (dbg_state !== S_IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %0d, expected %0d", dbg_state, S_IDLE);
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle_busy: got %b, expected 0", busy);
        end
    endtask

    task automatic test_ws_len4();
        run_cmd(1'b0, 8'd4, 1'b0);
        build_exp(1'b0, 4);
        n_cmp++;
        if (tr.size() !== 30) begin
            n_err++;
            $display("FAIL ws4_length: got %0d cycles, expected 30", tr.size());
        end
        n_cmp++;
        if (tr[28].done !== 1'b1) begin
            n_err++;
            $display("FAIL ws4_done_cycle29: got %b, expected 1", tr[28].done);
        end
        for (int i = 0; i < tr.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (tr[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL ws4_cycle%0d: got %h, expected %h", i + 1, tr[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_os_len3();
        run_cmd(1'b1, 8'd3, 1'b0);
        build_exp(1'b1, 3);
        n_cmp++;
        if (tr.size() !== 22) begin
            n_err++;
            $display("FAIL os3_length: got %0d cycles, expected 22", tr.size());
        end
        n_cmp++;
        if (tr[20].done !== 1'b1) begin
            n_err++;
            $display("FAIL os3_done_cycle21: got %b, expected 1", tr[20].done);
        end
        for (int i = 0; i < tr.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (tr[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL os3_cycle%0d: got %h, expected %h", i + 1, tr[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_len0();
        run_cmd(1'b0, 8'd0, 1'b0);
        build_exp(1'b0, 0);
        n_cmp++;
        if (tr.size() !== 26 || tr[24].done !== 1'b1) begin
            n_err++;
            $display("FAIL ws0_done_cycle25: got %0d cycles done=%b, expected 26 cycles done=1", tr.size(), tr[24].done);
        end
        for (int i = 0; i < tr.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (tr[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL ws0_cycle%0d: got %h, expected %h", i + 1, tr[i], exp_q[i]);
            end
        end
        run_cmd(1'b1, 8'd0, 1'b0);
        build_exp(1'b1, 0);
        n_cmp++;
        if (tr.size() !== 19 || tr[17].done !== 1'b1) begin
            n_err++;
            $display("FAIL os0_done_cycle18: got %0d cycles done=%b, expected 19 cycles done=1", tr.size(), tr[17].done);
        end
        for (int i = 0; i < tr.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (tr[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL os0_cycle%0d: got %h, expected %h", i + 1, tr[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        int n;
        start = 1'b1; cfg_mode = 1'b0; cfg_len = 8'd2;
        @(posedge clk); #1;
        tr.delete();
        tr.push_back(sample_outputs());
        for (int i = 1; i < 29; i++) begin
            @(posedge clk); #1;
            tr.push_back(sample_outputs());
        end
        start = 1'b0;
        build_exp(1'b0, 2);
        dones = 0;
        for (int i = 0; i < 28; i++) begin
            if (tr[i].done === 1'b1) dones++;
            n_cmp++;
            if (tr[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL b2b_cycle%0d: got %h, expected %h", i + 1, tr[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (dones !== 1) begin
            n_err++;
            $display("FAIL b2b_single_done: got %0d, expected 1", dones);
        end
        n_cmp++;
        if (tr[28].inst_w !== 2'b01 || tr[28].w_addr !== AW'(0) || tr[28].busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_second_load: got inst_w=%b w_addr=%0d busy=%b, expected 01/0/1",
                     tr[28].inst_w, tr[28].w_addr, tr[28].busy);
        end
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_second_done: got %b after %0d cycles, expected 1", done, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int seen;
        start = 1'b1; cfg_mode = 1'b0; cfg_len = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_cmp++;
        if (inst_w !== 2'b10 || x_addr !== AW'(1)) begin
            n_err++;
            $display("FAIL rst_mid_exec2: got inst_w=%b x_addr=%0d, expected 10/1", inst_w, x_addr);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (sample_outputs() !== obs_t'(0)) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got %h, expected 0", sample_outputs());
        end
        reset = 1'b1;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL rst_mid_no_done: got %0d busy/done cycles, expected 0", seen);
        end
        run_cmd(1'b1, 8'd1, 1'b0);
        build_exp(1'b1, 1);
        n_cmp++;
        if (tr.size() !== exp_q.size()) begin
            n_err++;
            $display("FAIL rst_mid_restart_length: got %0d, expected %0d", tr.size(), exp_q.size());
        end
        for (int i = 0; i < tr.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (tr[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL rst_mid_restart_cycle%0d: got %h, expected %h", i + 1, tr[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_cfg_toggle();
        run_cmd(1'b1, 8'd3, 1'b1);
        cfg_mode = 1'b0; cfg_len = '0;
        build_exp(1'b1, 3);
        n_cmp++;
        if (tr.size() !== 22) begin
            n_err++;
            $display("FAIL cfg_toggle_length: got %0d cycles, expected 22", tr.size());
        end
        for (int i = 0; i < tr.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (tr[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL cfg_toggle_cycle%0d: got %h, expected %h", i + 1, tr[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ws_len4();
        test_os_len3();
        test_len0();
        test_back_to_back();
        test_reset_mid();
        test_cfg_toggle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
